// File: rtl/single_cycle_cpu.sv
// -----------------------------------------------------------------------------
// single_cycle_cpu
//   Single-cycle RV32I integer core (no CSRs, no traps). Every instruction is
//   fetched, decoded, executed and written back within one clock period.
//   Illegal or unsupported encodings (FENCE, SYSTEM, all-zero word) retire as
//   NOPs: PC+4, no register write, no memory write.
//
// Ports
//   clk     in   rising-edge clock for PC, register file and data RAM
//   reset   in   asynchronous active-low reset (0 = in reset)
//   iaddr   out  byte address of current instruction (= PC)
//   idata   in   instruction word at iaddr, combinational
//   daddr   out  load/store byte address (rs1 + imm)
//   drdata  in   aligned word containing daddr, combinational
//   dwdata  out  store data replicated into the byte lanes
//   dwe     out  per-byte write enable, bit k writes lane k
//
// Also contains single_cycle_cpu_regfile, instantiated as ureg, whose array
// RF[0:31] is the architectural register file.
// -----------------------------------------------------------------------------

module single_cycle_cpu_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);
   logic [31:0] RF [0:31];

   // NOTE: the register array is cleared by reset, so it is built from
   // resettable flops rather than a RAM macro; that is required here because
   // the architectural state must be zero after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) RF[i] <= '0;
      end else if (we_i && (wa_i != 5'd0)) begin
         RF[wa_i] <= wd_i;
      end
   end

   // x0 is hard-wired: it is never written, and the read mux forces zero too.
   assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : RF[ra1_i];
   assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : RF[ra2_i];
endmodule

module single_cycle_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] iaddr,
   input  logic [31:0] idata,
   output logic [31:0] daddr,
   input  logic [31:0] drdata,
   output logic [31:0] dwdata,
   output logic [3:0]  dwe
);
   typedef enum logic [6:0] {
      OPC_LOAD   = 7'h03,
      OPC_OP_IMM = 7'h13,
      OPC_AUIPC  = 7'h17,
      OPC_STORE  = 7'h23,
      OPC_OP     = 7'h33,
      OPC_LUI    = 7'h37,
      OPC_BRANCH = 7'h63,
      OPC_JALR   = 7'h67,
      OPC_JAL    = 7'h6F
   } opcode_e;

   logic [31:0] pc_q, pc_d, pc_plus4;
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [2:0]  funct3;
   logic        rf_we;
   logic [31:0] rf_wd;
   logic [3:0]  store_we;
   logic        taken;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign funct3   = idata[14:12];
   assign pc_plus4 = pc_q + 32'd4;
   assign iaddr    = pc_q;

   assign imm_i = {{20{idata[31]}}, idata[31:20]};
   assign imm_s = {{20{idata[31]}}, idata[31:25], idata[11:7]};
   assign imm_b = {{19{idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0};
   assign imm_u = {idata[31:12], 12'b0};
   assign imm_j = {{11{idata[31]}}, idata[31], idata[19:12], idata[20], idata[30:21], 1'b0};

   // Loads use the I immediate, stores the S immediate; both share daddr.
   assign daddr = rs1_val + ((idata[6:0] == OPC_STORE) ? imm_s : imm_i);

   // A store word may sit at idata during reset; the RAM must not see it.
   assign dwe = reset ? store_we : 4'b0000;

   single_cycle_cpu_regfile ureg (
      .clk   (clk),
      .reset (reset),
      .ra1_i (idata[19:15]),
      .ra2_i (idata[24:20]),
      .rd1_o (rs1_val),
      .rd2_o (rs2_val),
      .we_i  (rf_we),
      .wa_i  (idata[11:7]),
      .wd_i  (rf_wd)
   );

   // alt selects SUB (register form only) or the arithmetic right shift.
   function automatic logic [31:0] alu(input logic [2:0]  f3,
                                       input logic        alt,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      logic [31:0] r;
      case (f3)
         3'd0:    r = alt ? (a - b) : (a + b);
         3'd1:    r = a << b[4:0];
         3'd2:    r = {31'd0, $signed(a) < $signed(b)};
         3'd3:    r = {31'd0, a < b};
         3'd4:    r = a ^ b;
         3'd5:    if (alt) r = $signed(a) >>> b[4:0];
                  else     r = a >> b[4:0];
         3'd6:    r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   always_comb begin
      case (daddr[1:0])
         2'd0:    ld_byte = drdata[7:0];
         2'd1:    ld_byte = drdata[15:8];
         2'd2:    ld_byte = drdata[23:16];
         default: ld_byte = drdata[31:24];
      endcase
      ld_half = daddr[1] ? drdata[31:16] : drdata[15:0];
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statements can leave one unassigned and infer a latch.
      pc_d     = pc_plus4;
      rf_we    = 1'b0;
      rf_wd    = '0;
      store_we = 4'b0000;
      dwdata   = '0;
      taken    = 1'b0;
      case (idata[6:0])
         OPC_LUI: begin
            rf_we = 1'b1;
            rf_wd = imm_u;
         end
         OPC_AUIPC: begin
            rf_we = 1'b1;
            rf_wd = pc_q + imm_u;
         end
         OPC_JAL: begin
            rf_we = 1'b1;
            rf_wd = pc_plus4;
            pc_d  = pc_q + imm_j;
         end
         OPC_JALR: begin
            if (funct3 == 3'd0) begin
               rf_we = 1'b1;
               rf_wd = pc_plus4;
               pc_d  = (rs1_val + imm_i) & ~32'd1;
            end
         end
         OPC_BRANCH: begin
            case (funct3)
               3'd0:    taken = (rs1_val == rs2_val);
               3'd1:    taken = (rs1_val != rs2_val);
               3'd4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
               3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
               3'd6:    taken = (rs1_val <  rs2_val);
               3'd7:    taken = (rs1_val >= rs2_val);
               default: taken = 1'b0;
            endcase
            if (taken) pc_d = pc_q + imm_b;
         end
         OPC_LOAD: begin
            rf_we = 1'b1;
            case (funct3)
               3'd0:    rf_wd = {{24{ld_byte[7]}}, ld_byte};
               3'd1:    rf_wd = {{16{ld_half[15]}}, ld_half};
               3'd2:    rf_wd = drdata;
               3'd4:    rf_wd = {24'd0, ld_byte};
               3'd5:    rf_wd = {16'd0, ld_half};
               default: rf_we = 1'b0;
            endcase
         end
         OPC_STORE: begin
            case (funct3)
               3'd0: begin
                  store_we = 4'b0001 << daddr[1:0];
                  dwdata   = {4{rs2_val[7:0]}};
               end
               3'd1: begin
                  store_we = daddr[1] ? 4'b1100 : 4'b0011;
                  dwdata   = {2{rs2_val[15:0]}};
               end
               3'd2: begin
                  store_we = 4'b1111;
                  dwdata   = rs2_val;
               end
               default: ;
            endcase
         end
         OPC_OP_IMM: begin
            // instr[30] is part of the immediate, so it only matters for SRAI.
            rf_we = 1'b1;
            rf_wd = alu(funct3, (funct3 == 3'd5) && idata[30], rs1_val, imm_i);
         end
         OPC_OP: begin
            rf_we = 1'b1;
            rf_wd = alu(funct3, idata[30], rs1_val, rs2_val);
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values; combinational logic above uses blocking ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// -----------------------------------------------------------------------------
// tb_single_cycle_cpu
//   Bench for single_cycle_cpu. Models the instruction ROM and a byte-lane data
//   RAM, loads small hand-encoded programs, and scores the DUT against queues of
//   expected PCs, stores and register values that are pushed when each program
//   is loaded and popped as the DUT executes it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_single_cycle_cpu;
   localparam int OPI   = 'h13;
   localparam int LD    = 'h03;
   localparam int LUI   = 'h37;
   localparam int AUIPC = 'h17;
   localparam int JALR  = 'h67;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] iaddr, idata, daddr, drdata, dwdata;
   logic [3:0]  dwe;

   single_cycle_cpu #(.RESET_PC(32'h0000_0000)) dut (
      .clk    (clk),
      .reset  (reset),
      .iaddr  (iaddr),
      .idata  (idata),
      .daddr  (daddr),
      .drdata (drdata),
      .dwdata (dwdata),
      .dwe    (dwe)
   );

   always #5 clk = ~clk;

   logic [31:0] rom  [0:63];
   logic [31:0] ram  [0:63];
   logic [31:0] snap [0:63];
   int          wp;

   assign idata  = rom[iaddr[7:2]];
   assign drdata = ram[daddr[7:2]];

   // A store cycle never loads, so updating the RAM on the edge cannot race
   // with a register write that depends on drdata.
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (dwe[k]) ram[daddr[7:2]][8*k +: 8] = dwdata[8*k +: 8];
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   typedef struct {
      string       tag;
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] data;
   } st_exp_t;

   typedef struct {
      string       tag;
      int          idx;
      logic [31:0] val;
   } rf_exp_t;

   logic [31:0] exp_pc_q [$];
   st_exp_t     st_q     [$];
   rf_exp_t     rf_q     [$];
   bit          mon_en = 1'b0;

   // Scoreboard consumer: one PC per executed instruction, one entry per store.
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_pc_q.size() > 0) check("pc", iaddr, exp_pc_q.pop_front());
         if (dwe != 4'b0000) begin
            if (st_q.size() == 0) begin
               check("unexpected_store_dwe", {28'd0, dwe}, 32'd0);
            end else begin
               st_exp_t e;
               e = st_q.pop_front();
               check({e.tag, "_daddr"}, daddr, e.addr);
               check({e.tag, "_dwe"}, {28'd0, dwe}, {28'd0, e.we});
               check({e.tag, "_dwdata"}, dwdata, e.data);
            end
         end
      end
   end

   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(int op, int imm, int rs1, int f3, int rd);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(int op, int imm20, int rd);
      return {imm20[19:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] enc_j(int imm, int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 32'h0;
      wp = 0;
   endtask

   task automatic put(input logic [31:0] ins);
      rom[wp] = ins;
      wp++;
   endtask

   task automatic exp_rf(input int idx, input logic [31:0] v);
      rf_q.push_back('{$sformatf("x%0d", idx), idx, v});
   endtask

   task automatic exp_st(input string tag, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d);
      st_q.push_back('{tag, a, w, d});
   endtask

   task automatic exp_pc_linear(input int n);
      for (int i = 0; i < n; i++) exp_pc_q.push_back(32'(i * 4));
   endtask

   // Release reset just after a rising edge; the next edge executes RESET_PC.
   task automatic run(input int n);
      @(posedge clk);
      #2;
      reset  = 1'b1;
      mon_en = 1'b1;
      repeat (n) @(posedge clk);
      #2;
      mon_en = 1'b0;
   endtask

   task automatic drain_rf();
      rf_exp_t e;
      while (rf_q.size() > 0) begin
         e = rf_q.pop_front();
         check(e.tag, dut.ureg.RF[e.idx], e.val);
      end
   endtask

   task automatic end_phase(input string tag, input logic [31:0] final_pc);
      check({tag, "_missing_stores"}, 32'(st_q.size()), 32'd0);
      check({tag, "_final_pc"}, iaddr, final_pc);
      drain_rf();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      clear_rom();
      for (int i = 0; i < 64; i++) ram[i] = 32'h0;

      // ---------------- reset ----------------
      #50;
      check("reset_iaddr", iaddr, 32'h0);
      check("reset_dwe", {28'd0, dwe}, 32'd0);
      #50;
      for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), dut.ureg.RF[i], 32'h0);
      exp_pc_q.push_back(32'h0);
      run(1);
      check("pc_after_first_edge", iaddr, 32'h4);

      // ---------------- ALU / upper / store / load ----------------
      reset = 1'b0;
      #10;
      clear_rom();
      ram[2] = 32'h0000_8080;
      put(enc_i(OPI, 5, 0, 0, 1));          // addi x1,x0,5
      put(enc_i(OPI, -3, 0, 0, 2));         // addi x2,x0,-3
      put(enc_r(0, 2, 1, 0, 3));            // add  x3,x1,x2
      put(enc_r('h20, 2, 1, 0, 4));         // sub  x4,x1,x2
      put(enc_r(0, 1, 2, 2, 5));            // slt  x5,x2,x1
      put(enc_r(0, 1, 2, 3, 6));            // sltu x6,x2,x1
      put(enc_i(OPI, 'h401, 2, 5, 8));      // srai x8,x2,1
      put(enc_u(LUI, 'h12345, 7));          // lui  x7,0x12345
      put(enc_i(OPI, 'h678, 7, 0, 7));      // addi x7,x7,0x678
      put(enc_s(0, 7, 0, 2));               // sw   x7,0(x0)
      put(enc_s(5, 1, 0, 0));               // sb   x1,5(x0)
      put(enc_i(LD, 8, 0, 0, 9));           // lb   x9,8(x0)
      put(enc_i(LD, 8, 0, 4, 10));          // lbu  x10,8(x0)
      put(enc_i(LD, 8, 0, 1, 11));          // lh   x11,8(x0)
      put(enc_i(LD, 8, 0, 5, 13));          // lhu  x13,8(x0)
      put(enc_i(LD, 8, 0, 2, 14));          // lw   x14,8(x0)
      put(enc_s(6, 2, 0, 1));               // sh   x2,6(x0)
      put(enc_r(0, 1, 2, 5, 15));           // srl  x15,x2,x1
      put(enc_r('h20, 1, 2, 5, 16));        // sra  x16,x2,x1
      put(enc_r(0, 1, 1, 1, 17));           // sll  x17,x1,x1
      put(enc_i(OPI, 'h0F0, 2, 4, 18));     // xori x18,x2,0xf0
      put(enc_i(OPI, 'h7FF, 2, 7, 19));     // andi x19,x2,0x7ff
      put(enc_i(OPI, -16, 1, 6, 20));       // ori  x20,x1,-16
      put(enc_i(OPI, -1, 1, 3, 21));        // sltiu x21,x1,-1
      put(enc_i(OPI, -4, 2, 2, 22));        // slti x22,x2,-4
      put(enc_i(OPI, 28, 2, 5, 23));        // srli x23,x2,28
      put(enc_i(OPI, 31, 1, 1, 24));        // slli x24,x1,31
      put(enc_r(0, 2, 1, 4, 25));           // xor  x25,x1,x2
      put(enc_r(0, 2, 1, 6, 26));           // or   x26,x1,x2
      put(enc_r(0, 2, 1, 7, 27));           // and  x27,x1,x2
      put(enc_r(0, 2, 1, 3, 28));           // sltu x28,x1,x2
      exp_pc_linear(31);
      exp_st("sw", 32'h0, 4'b1111, 32'h1234_5678);
      exp_st("sb", 32'h5, 4'b0010, 32'h0505_0505);
      exp_st("sh", 32'h6, 4'b1100, 32'hFFFD_FFFD);
      exp_rf(0, 32'h0);            exp_rf(1, 32'h5);
      exp_rf(2, 32'hFFFF_FFFD);    exp_rf(3, 32'h2);
      exp_rf(4, 32'h8);            exp_rf(5, 32'h1);
      exp_rf(6, 32'h0);            exp_rf(7, 32'h1234_5678);
      exp_rf(8, 32'hFFFF_FFFE);    exp_rf(9, 32'hFFFF_FF80);
      exp_rf(10, 32'h0000_0080);   exp_rf(11, 32'hFFFF_8080);
      exp_rf(13, 32'h0000_8080);   exp_rf(14, 32'h0000_8080);
      exp_rf(15, 32'h07FF_FFFF);   exp_rf(16, 32'hFFFF_FFFF);
      exp_rf(17, 32'h0000_00A0);   exp_rf(18, 32'hFFFF_FF0D);
      exp_rf(19, 32'h0000_07FD);   exp_rf(20, 32'hFFFF_FFF5);
      exp_rf(21, 32'h1);           exp_rf(22, 32'h0);
      exp_rf(23, 32'hF);           exp_rf(24, 32'h8000_0000);
      exp_rf(25, 32'hFFFF_FFF8);   exp_rf(26, 32'hFFFF_FFFD);
      exp_rf(27, 32'h5);           exp_rf(28, 32'h1);
      run(31);
      end_phase("alu", 32'h7C);
      check("mem_word0", ram[0], 32'h1234_5678);
      check("mem_word1_byte1", {24'd0, ram[1][15:8]}, 32'h05);
      check("mem_word1", ram[1], 32'hFFFD_0500);
      check("mem_word2", ram[2], 32'h0000_8080);

      // ---------------- control flow ----------------
      reset = 1'b0;
      #10;
      clear_rom();
      put(enc_i(OPI, 5, 0, 0, 1));          // 00 addi x1,x0,5
      put(enc_i(OPI, -3, 0, 0, 2));         // 04 addi x2,x0,-3
      put(enc_b(8, 1, 1, 0));               // 08 beq  x1,x1,+8
      put(enc_i(OPI, 1, 0, 0, 20));         // 0c skipped
      put(enc_b(8, 1, 2, 4));               // 10 blt  x2,x1,+8 (taken)
      put(enc_i(OPI, 1, 0, 0, 21));         // 14 skipped
      put(enc_b(8, 1, 2, 6));               // 18 bltu x2,x1,+8 (not taken)
      put(enc_b(8, 1, 1, 1));               // 1c bne  x1,x1,+8 (not taken)
      put(enc_j(8, 12));                    // 20 jal  x12,+8
      put(enc_b(12, 2, 1, 5));              // 24 bge  x1,x2,+12 (taken)
      put(enc_i(JALR, 1, 12, 0, 0));        // 28 jalr x0,x12,1
      put(enc_i(OPI, 1, 0, 0, 24));         // 2c skipped
      put(enc_b(8, 2, 1, 7));               // 30 bgeu x1,x2,+8 (not taken)
      put(enc_u(AUIPC, 1, 23));             // 34 auipc x23,1
      put(enc_j(0, 0));                     // 38 jal  x0,0
      foreach (snap[i]) snap[i] = 32'h0;
      exp_pc_q.push_back(32'h00); exp_pc_q.push_back(32'h04);
      exp_pc_q.push_back(32'h08); exp_pc_q.push_back(32'h10);
      exp_pc_q.push_back(32'h18); exp_pc_q.push_back(32'h1C);
      exp_pc_q.push_back(32'h20); exp_pc_q.push_back(32'h28);
      exp_pc_q.push_back(32'h24); exp_pc_q.push_back(32'h30);
      exp_pc_q.push_back(32'h34); exp_pc_q.push_back(32'h38);
      exp_pc_q.push_back(32'h38);
      exp_rf(1, 32'h5);            exp_rf(12, 32'h24);
      exp_rf(20, 32'h0);           exp_rf(21, 32'h0);
      exp_rf(23, 32'h1034);        exp_rf(24, 32'h0);
      exp_rf(0, 32'h0);
      run(13);
      end_phase("ctl", 32'h38);

      // ---------------- x0 write and NOP stream ----------------
      reset = 1'b0;
      #10;
      clear_rom();
      put(enc_i(OPI, 5, 0, 0, 1));          // addi x1,x0,5
      put(enc_i(OPI, 7, 0, 0, 0));          // addi x0,x0,7
      for (int i = 0; i < 64; i++) snap[i] = ram[i];
      exp_pc_linear(42);
      for (int i = 0; i < 32; i++) exp_rf(i, (i == 1) ? 32'h5 : 32'h0);
      run(42);
      end_phase("nop", 32'hA8);
      for (int i = 0; i < 64; i++) check($sformatf("nop_mem%0d", i), ram[i], snap[i]);

      // ---------------- reset asserted mid-program ----------------
      reset = 1'b0;
      #10;
      clear_rom();
      put(enc_s(16, 1, 0, 2));              // sw   x1,16(x0)
      put(enc_i(OPI, 5, 0, 0, 1));          // addi x1,x0,5
      put(enc_j(0, 0));                     // jal  x0,0
      exp_pc_linear(3);
      exp_st("sw_first", 32'h10, 4'b1111, 32'h0);
      exp_rf(1, 32'h5);
      run(3);
      end_phase("mid_pre", 32'h8);
      reset = 1'b0;
      #1;
      check("mid_reset_iaddr", iaddr, 32'h0);
      check("mid_reset_x1", dut.ureg.RF[1], 32'h0);
      check("mid_reset_dwe", {28'd0, dwe}, 32'd0);
      exp_pc_q.push_back(32'h0);
      exp_st("sw_restart", 32'h10, 4'b1111, 32'h0);
      run(1);
      end_phase("mid_post", 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
